// File: rtl/mant_mul_seq.sv
// Sequential shift-and-add mantissa multiplier, one conditional 2N-bit add per clock.
// Define MANT_MUL_EARLY_EXIT_EN to finish as soon as the remaining multiplier bits are zero.

module mant_mul_seq_rca #(
  parameter int unsigned W = 48
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         cin_i,
  output logic [W-1:0] sum_o,
  output logic         cout_o
);

  logic [W:0] carry;

  always_comb begin
    carry    = '0;
    sum_o    = '0;
    carry[0] = cin_i;
    for (int i = 0; i < int'(W); i++) begin
      sum_o[i]     = a_i[i] ^ b_i[i] ^ carry[i];
      carry[i + 1] = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
    end
    cout_o = carry[W];
  end

endmodule

module mant_mul_seq #(
  parameter int unsigned N = 24
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] product,
  output logic           busy
);

  localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [2*N-1:0]   acc_q, acc_d;
  logic [2*N-1:0]   mcand_q, mcand_d;
  logic [2*N-1:0]   product_q, product_d;
  logic [N-1:0]     mplier_q, mplier_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [2*N-1:0]   sum;
  logic             cout_unused;
  logic             last_iter;

  // Carry-out can never be set: the partial sum is bounded by a*b < 2^(2N).
  mant_mul_seq_rca #(
    .W (2 * N)
  ) u_adder (
    .a_i    (acc_q),
    .b_i    (mcand_q),
    .cin_i  (1'b0),
    .sum_o  (sum),
    .cout_o (cout_unused)
  );

  always_comb begin
`ifdef MANT_MUL_EARLY_EXIT_EN
    last_iter = ((mplier_q >> 1) == '0) || (cnt_q == CntW'(N - 1));
`else
    last_iter = (cnt_q == CntW'(N - 1));
`endif
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          acc_d    = '0;
          mcand_d  = {{N{1'b0}}, a};
          mplier_d = b;
          cnt_d    = '0;
          state_d  = StRun;
        end
      end
      StRun: begin
        acc_d    = mplier_q[0] ? sum : acc_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CntW'(1);
        if (last_iter) begin
          product_d = acc_d;
          state_d   = StDone;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  assign in_ready  = (state_q == StIdle) && !rst;
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q != StIdle);
  assign product   = product_q;

endmodule

// File: tb/tb_mant_mul_seq.sv
// Scoreboard bench for mant_mul_seq: reference products and latencies are queued on accept
// and compared by an independent output monitor.

module tb_mant_mul_seq;

  localparam int N = 24;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [N-1:0]   a = '0;
  logic [N-1:0]   b = '0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [2*N-1:0] product;
  logic           busy;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  bit rnd_or = 1'b0;
  bit ov_prev = 1'b0;

  logic [2*N-1:0] exp_q[$];
  int             lat_q[$];
  int             acc_cyc_q[$];

  mant_mul_seq #(
    .N (N)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    if (rnd_or) out_ready = 1'($urandom_range(0, 1));
  end

  function automatic logic [2*N-1:0] ref_mul(input logic [N-1:0] av, input logic [N-1:0] bv);
    logic [2*N-1:0] x;
    logic [2*N-1:0] y;
    x = (2*N)'(av);
    y = (2*N)'(bv);
    return x * y;
  endfunction

  function automatic int ref_lat(input logic [N-1:0] bv);
`ifdef MANT_MUL_EARLY_EXIT_EN
    int l = 1;
    for (int i = 0; i < N; i++) if (bv[i]) l = i + 1;
    return l;
`else
    return N;
`endif
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Issue-side scoreboard push: handshake completes on the following rising edge.
  always @(negedge clk) begin
    if (!rst && in_valid && in_ready) begin
      exp_q.push_back(ref_mul(a, b));
      lat_q.push_back(ref_lat(b));
      acc_cyc_q.push_back(cyc + 1);
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && !ov_prev) begin
        if (lat_q.size() == 0) begin
          check("unexpected_out_valid", 64'(out_valid), 64'd0);
        end else begin
          check("latency", 64'(cyc - acc_cyc_q.pop_front()), 64'(lat_q.pop_front()));
        end
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_product", 64'(product), 64'd0);
        end else begin
          check("product", 64'(product), 64'(exp_q.pop_front()));
        end
      end
    end
    ov_prev = out_valid && !rst;
  end

  task automatic issue(input logic [N-1:0] av, input logic [N-1:0] bv);
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    a = av;
    b = bv;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        return;
      end
    end
    check("issue_timeout", 64'd1, 64'd0);
    in_valid = 1'b0;
  endtask

  task automatic wait_ov();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (out_valid) return;
    end
    check("out_valid_timeout", 64'd0, 64'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !out_valid) begin
        @(posedge clk);
        #1;
        return;
      end
    end
    check("drain_timeout", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    logic [2*N-1:0] exp_p;
    int             ov_cnt;
    logic [N-1:0]   ra;
    logic [N-1:0]   rb;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_product", 64'(product), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("in_ready_after_rst", 64'(in_ready), 64'd1);

    // 3 * 5 with consumer always ready
    out_ready = 1'b1;
    issue(24'd3, 24'd5);
    check("busy_in_run", 64'(busy), 64'd1);
    check("in_ready_in_run", 64'(in_ready), 64'd0);
    wait_ov();
    check("p_3x5", 64'(product), 64'h0000_0000_000F);
    @(negedge clk);
    check("in_ready_back", 64'(in_ready), 64'd1);
    check("out_valid_drop", 64'(out_valid), 64'd0);

    issue(24'hFF_FFFF, 24'hFF_FFFF);
    wait_ov();
    check("p_max", 64'(product), 64'hFFFF_FE00_0001);
    drain();

    issue(24'hAB_CDEF, 24'd1);
    drain();
    issue(24'h12_3456, 24'd0);
    drain();

    // Stall in DONE with fresh operands presented
    out_ready = 1'b0;
    issue(24'h00_1234, 24'h00_5678);
    exp_p = ref_mul(24'h00_1234, 24'h00_5678);
    wait_ov();
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      a = N'($urandom);
      b = N'($urandom);
      @(negedge clk);
      check("stall_out_valid", 64'(out_valid), 64'd1);
      check("stall_product", 64'(product), 64'(exp_p));
      check("stall_in_ready", 64'(in_ready), 64'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain();

    // Abort mid-run
    issue(24'h55_5555, 24'hAA_AAAA);
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    exp_q.delete();
    lat_q.delete();
    acc_cyc_q.delete();
    @(negedge clk);
    check("abort_in_ready_rst", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_product", 64'(product), 64'd0);
    check("abort_out_valid", 64'(out_valid), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_in_ready", 64'(in_ready), 64'd1);
    ov_cnt = 0;
    for (int i = 0; i < N + 4; i++) begin
      @(negedge clk);
      if (out_valid) ov_cnt++;
    end
    check("abort_no_pulse", 64'(ov_cnt), 64'd0);
    issue(24'd2, 24'd7);
    wait_ov();
    check("p_2x7", 64'(product), 64'd14);
    drain();

    // Random operands with random consumer stalls
    rnd_or = 1'b1;
    for (int k = 0; k < 500; k++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      ra = N'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? N'($urandom_range(0, 15)) : N'($urandom);
      issue(ra, rb);
    end
    rnd_or = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    drain();
    check("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mant_mul_seq.md
MANT_MUL_SEQ -- requirements
Module: mant_mul_seq

Interface
REQ-001 SHALL have parameter N, default 24, operand width in bits (product width 2N).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port in_valid  input  1  operands a/b presented.
REQ-005 SHALL have port in_ready  output  1  block can accept operands.
REQ-006 SHALL have port a  input  N  multiplicand mantissa, unsigned.
REQ-007 SHALL have port b  input  N  multiplier mantissa, unsigned.
REQ-008 SHALL have port out_valid  output  1  product valid.
REQ-009 SHALL have port out_ready  input  1  consumer accepts product.
REQ-010 SHALL have port product  output  2N  unsigned a*b, registered.
REQ-011 SHALL have port busy  output  1  high in RUN or DONE.

Function
REQ-012 SHALL compute product = a*b by shift-and-add: one conditional 2N-bit add per clock, using one instance of the team's 2N-bit ripple-carry adder with cin tied 0.
REQ-013 SHALL implement states IDLE, RUN, DONE.
REQ-014 IDLE: in_ready=1; on edge with in_valid=1 SHALL load acc=0, mcand=zero-extended a, mplier=b, cnt=0, go to RUN.
REQ-015 RUN: each edge SHALL set acc=acc+mcand if mplier[0]=1 else hold acc; mcand<<=1; mplier>>=1; cnt+=1.
REQ-016 RUN SHALL go to DONE on the edge where cnt==N-1 (N iterations total); product register loaded with final acc on that edge.
REQ-017 Latency: out_valid SHALL rise exactly N edges after the accepting edge (24 for default).
REQ-018 DONE: out_valid=1, product stable; on edge with out_ready=1 SHALL go to IDLE and drop out_valid.
REQ-019 in_ready SHALL be 0 in RUN and DONE; in_valid there ignored, a/b changes have no effect.
REQ-020 No back-to-back accept: minimum issue interval N+2 edges (accept, N iterations, drain).
REQ-021 Adder carry-out SHALL be ignored; it is always 0 for unsigned NxN operands.
REQ-022 product SHALL hold its last value in IDLE and RUN until next DONE load.
REQ-023 out_ready while out_valid=0 SHALL have no effect.

Reset
REQ-024 On any edge with rst=1 SHALL force state=IDLE, acc=0, mcand=0, mplier=0, cnt=0, product=0, out_valid=0, busy=0.
REQ-025 in_ready SHALL be 0 while rst=1 and 1 on the first cycle after rst deasserts.
REQ-026 rst in RUN or DONE SHALL abort the operation; no out_valid pulse for the aborted operation.
REQ-027 rst SHALL dominate in_valid and out_ready on the same edge.

Configuration
REQ-028 Macro MANT_MUL_EARLY_EXIT_EN SHALL select early termination.
REQ-029 With MANT_MUL_EARLY_EXIT_EN defined: RUN SHALL go to DONE on the first edge where the post-shift mplier is 0 or cnt==N-1; latency = 1 + index of highest set bit of b (1 for b=0 or b=1).
REQ-030 Without MANT_MUL_EARLY_EXIT_EN: latency SHALL be exactly N for all operands.
REQ-031 Product value SHALL be identical in both builds.

Verification
REQ-032 a=3, b=5, out_ready=1 -> product=0x00000000000F, out_valid rises 24 edges after accept, in_ready back 1 edge later.
REQ-033 a=b=0xFFFFFF -> product=0xFFFFFE000001; adder cout never 1.
REQ-034 Hold out_ready=0 for 10 cycles in DONE -> out_valid and product stable; in_valid=1 with new operands ignored.
REQ-035 rst pulsed at RUN cycle 10 -> next edge state IDLE, product=0, out_valid=0; new op a=2, b=7 -> product=14 normally.
REQ-036 a=0xABCDEF, b=1 -> product=0x000000ABCDEF; latency 1 with MANT_MUL_EARLY_EXIT_EN, 24 without.
REQ-037 500 random (a,b) with random out_ready stalls -> every product equals reference a*b, one output per accepted input, in order.
